// File: rtl/dcache_nway.sv
// Parametrised write-back, write-allocate data cache between the load/store trinity bus
// and the memory arbiter, with round-robin replacement and a whole-cache flush sequencer.
`ifndef TBUS_RANGE
`define TBUS_RANGE 1:0
`endif
`ifndef TBUS_WRITE
`define TBUS_WRITE 2'b01
`endif
`ifndef TBUS_READ
`define TBUS_READ 2'b00
`endif

module dcache_nway #(
    parameter int WAYS       = 2,
    parameter int SETS       = 64,
    parameter int LINE_WORDS = 8
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               tbus_index_valid,
    output logic               tbus_index_ready,
    input  logic [63:0]        tbus_index,
    input  logic [63:0]        tbus_write_data,
    input  logic [63:0]        tbus_write_mask,
    input  logic [`TBUS_RANGE] tbus_operation_type,
    output logic [63:0]        tbus_read_data,
    output logic               tbus_operation_done,
    input  logic               flush_req,
    output logic               flush_done,
    output logic               dcache2arb_tbus_index_valid,
    input  logic               dcache2arb_tbus_index_ready,
    output logic [63:0]        dcache2arb_tbus_index,
    output logic [63:0]        dcache2arb_tbus_write_data,
    output logic [63:0]        dcache2arb_tbus_write_mask,
    output logic [`TBUS_RANGE] dcache2arb_tbus_operation_type,
    input  logic [63:0]        dcache2arb_tbus_read_data,
    input  logic               dcache2arb_tbus_operation_done
);
    localparam int KW = $clog2(LINE_WORDS);
    localparam int OB = KW + 3;
    localparam int SW = $clog2(SETS);
    localparam int TW = 64 - OB - SW;
    localparam int WW = (WAYS > 1) ? $clog2(WAYS) : 1;

    typedef enum logic [3:0] {
        IDLE, LOOKUP, WB_REQ, WB_WAIT, RF_REQ, RF_WAIT, RESP,
        FL_SCAN, FL_REQ, FL_WAIT, FL_DONE
    } state_t;

    state_t state, state_next;

    logic [SETS-1:0] valid_q [WAYS];
    logic [SETS-1:0] dirty_q [WAYS];
    logic [TW-1:0]   tag_q   [WAYS][SETS];
    logic [63:0]     data_q  [WAYS][SETS][LINE_WORDS];
    logic [WW-1:0]   rr_q    [SETS];
    logic [63:0]     line_buf [LINE_WORDS];

    logic [63:3]   req_addr;
    logic [63:0]   req_wdata, req_mask;
    logic          req_store;
    logic [WW-1:0] way, fl_way, hit_way, victim;
    logic [SW-1:0] fl_set;
    logic [KW-1:0] beat;

    logic [SW-1:0] req_set;
    logic [KW-1:0] req_word;
    logic [TW-1:0] req_tag;
    logic          hit, victim_free, victim_dirty, line_dirty;
    logic          beat_last, last_line, mem_done, fl_advance;
    logic          unused_addr_bits;

    assign req_set          = req_addr[OB+SW-1:OB];
    assign req_word         = req_addr[OB-1:3];
    assign req_tag          = req_addr[63:OB+SW];
    assign unused_addr_bits = ^tbus_index[2:0];
    assign mem_done         = dcache2arb_tbus_operation_done;
    assign beat_last        = &beat;
    assign last_line        = (fl_set == SW'(SETS-1)) && (fl_way == WW'(WAYS-1));
    assign victim_dirty     = valid_q[victim][req_set] && dirty_q[victim][req_set];
    assign line_dirty       = valid_q[fl_way][fl_set] && dirty_q[fl_way][fl_set];
    assign fl_advance       = !last_line &&
                              ((state == FL_SCAN && !line_dirty) ||
                               (state == FL_WAIT && mem_done && beat_last));

    // Tag compare and victim choice; the descending loop leaves the lowest invalid way.
    always_comb begin
        hit         = 1'b0;
        hit_way     = '0;
        victim      = rr_q[req_set];
        victim_free = 1'b0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (valid_q[w][req_set] && tag_q[w][req_set] == req_tag) begin
                hit     = 1'b1;
                hit_way = WW'(w);
            end
            if (!valid_q[w][req_set]) begin
                victim      = WW'(w);
                victim_free = 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (flush_req) state_next = FL_SCAN;
                     else if (tbus_index_valid) state_next = LOOKUP;
            LOOKUP:  state_next = hit ? RESP : (victim_dirty ? WB_REQ : RF_REQ);
            WB_REQ:  if (dcache2arb_tbus_index_ready) state_next = WB_WAIT;
            WB_WAIT: if (mem_done) state_next = beat_last ? RF_REQ : WB_REQ;
            RF_REQ:  if (dcache2arb_tbus_index_ready) state_next = RF_WAIT;
            RF_WAIT: if (mem_done) state_next = beat_last ? RESP : RF_REQ;
            RESP:    state_next = IDLE;
            FL_SCAN: if (line_dirty) state_next = FL_REQ;
                     else if (last_line) state_next = FL_DONE;
            FL_REQ:  if (dcache2arb_tbus_index_ready) state_next = FL_WAIT;
            FL_WAIT: if (mem_done) state_next = !beat_last ? FL_REQ :
                                                (last_line ? FL_DONE : FL_SCAN);
            FL_DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        tbus_index_ready               = (state == IDLE) && !flush_req;
        tbus_operation_done            = (state == RESP);
        tbus_read_data                 = '0;
        flush_done                     = (state == FL_DONE);
        dcache2arb_tbus_index_valid    = 1'b0;
        dcache2arb_tbus_index          = '0;
        dcache2arb_tbus_write_data     = '0;
        dcache2arb_tbus_write_mask     = '0;
        dcache2arb_tbus_operation_type = '0;
        case (state)
            RESP: if (!req_store) tbus_read_data = data_q[way][req_set][req_word];
            WB_REQ: begin
                dcache2arb_tbus_index_valid    = 1'b1;
                dcache2arb_tbus_index          = {tag_q[way][req_set], req_set, beat, 3'b000};
                dcache2arb_tbus_write_data     = data_q[way][req_set][beat];
                dcache2arb_tbus_write_mask     = '1;
                dcache2arb_tbus_operation_type = `TBUS_WRITE;
            end
            FL_REQ: begin
                dcache2arb_tbus_index_valid    = 1'b1;
                dcache2arb_tbus_index          = {tag_q[fl_way][fl_set], fl_set, beat, 3'b000};
                dcache2arb_tbus_write_data     = data_q[fl_way][fl_set][beat];
                dcache2arb_tbus_write_mask     = '1;
                dcache2arb_tbus_operation_type = `TBUS_WRITE;
            end
            RF_REQ: begin
                dcache2arb_tbus_index_valid    = 1'b1;
                dcache2arb_tbus_index          = {req_tag, req_set, beat, 3'b000};
                dcache2arb_tbus_operation_type = `TBUS_READ;
            end
            default: ;
        endcase
    end

    // Storage, request latch and sequencing counters; the beat counter wraps to 0 after each line.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int w = 0; w < WAYS; w++) begin
                valid_q[w] <= '0;
                dirty_q[w] <= '0;
            end
            for (int s = 0; s < SETS; s++) rr_q[s] <= '0;
            beat   <= '0;
            fl_set <= '0;
            fl_way <= '0;
            way    <= '0;
        end else begin
            if (fl_advance) begin
                if (fl_way == WW'(WAYS-1)) begin
                    fl_way <= '0;
                    fl_set <= fl_set + 1'b1;
                end else begin
                    fl_way <= fl_way + 1'b1;
                end
            end
            case (state)
                IDLE: begin
                    beat <= '0;
                    if (flush_req) begin
                        fl_set <= '0;
                        fl_way <= '0;
                    end else if (tbus_index_valid) begin
                        req_addr  <= tbus_index[63:3];
                        req_wdata <= tbus_write_data;
                        req_mask  <= tbus_write_mask;
                        req_store <= (tbus_operation_type == `TBUS_WRITE);
                    end
                end
                LOOKUP: begin
                    beat <= '0;
                    if (hit) begin
                        way <= hit_way;
                    end else begin
                        way <= victim;
                        if (!victim_free)
                            rr_q[req_set] <= (rr_q[req_set] == WW'(WAYS-1)) ? '0 : rr_q[req_set] + 1'b1;
                    end
                end
                WB_WAIT, FL_WAIT: if (mem_done) beat <= beat + 1'b1;
                RF_WAIT: if (mem_done) begin
                    beat           <= beat + 1'b1;
                    line_buf[beat] <= dcache2arb_tbus_read_data;
                    if (beat_last) begin
                        for (int k = 0; k < LINE_WORDS; k++)
                            data_q[way][req_set][k] <= (k == LINE_WORDS - 1) ?
                                                       dcache2arb_tbus_read_data : line_buf[k];
                        tag_q[way][req_set]   <= req_tag;
                        valid_q[way][req_set] <= 1'b1;
                        dirty_q[way][req_set] <= 1'b0;
                    end
                end
                RESP: if (req_store) begin
                    data_q[way][req_set][req_word] <= (data_q[way][req_set][req_word] & ~req_mask) |
                                                      (req_wdata & req_mask);
                    dirty_q[way][req_set] <= 1'b1;
                end
                FL_DONE: begin
                    for (int w = 0; w < WAYS; w++) begin
                        valid_q[w] <= '0;
                        dirty_q[w] <= '0;
                    end
                    for (int s = 0; s < SETS; s++) rr_q[s] <= '0;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_dcache_nway.sv
// Self-checking bench for dcache_nway (2 ways, 4 sets, 2-word lines): directed scenarios plus
// randomized traffic checked against a flat golden memory and a set/tag occupancy model.
`ifndef TBUS_RANGE
`define TBUS_RANGE 1:0
`endif
`ifndef TBUS_WRITE
`define TBUS_WRITE 2'b01
`endif
`ifndef TBUS_READ
`define TBUS_READ 2'b00
`endif

module tb_dcache_nway;
    localparam int WAYS = 2;
    localparam int SETS = 4;
    localparam int LW   = 2;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic t_valid = 1'b0, t_ready, t_done, flush_req = 1'b0, f_done;
    logic [63:0] t_index = '0, t_wdata = '0, t_wmask = '0, t_rdata;
    logic [`TBUS_RANGE] t_op = '0;
    logic m_valid, m_ready = 1'b0, m_done = 1'b0;
    logic [63:0] m_index, m_wdata, m_wmask, m_rdata = '0;
    logic [`TBUS_RANGE] m_op;

    int checks = 0;
    int failures = 0;

    always #5 clock = ~clock;

    dcache_nway #(.WAYS(WAYS), .SETS(SETS), .LINE_WORDS(LW)) dut (
        .clock(clock), .reset(reset),
        .tbus_index_valid(t_valid), .tbus_index_ready(t_ready), .tbus_index(t_index),
        .tbus_write_data(t_wdata), .tbus_write_mask(t_wmask), .tbus_operation_type(t_op),
        .tbus_read_data(t_rdata), .tbus_operation_done(t_done),
        .flush_req(flush_req), .flush_done(f_done),
        .dcache2arb_tbus_index_valid(m_valid), .dcache2arb_tbus_index_ready(m_ready),
        .dcache2arb_tbus_index(m_index), .dcache2arb_tbus_write_data(m_wdata),
        .dcache2arb_tbus_write_mask(m_wmask), .dcache2arb_tbus_operation_type(m_op),
        .dcache2arb_tbus_read_data(m_rdata), .dcache2arb_tbus_operation_done(m_done)
    );

    // Backing memory, golden architectural memory and the log of every memory beat.
    logic [63:0] mem  [logic [63:0]];
    logic [63:0] gold [logic [63:0]];
    logic [63:0] log_addr[$], log_data[$], log_mask[$];
    bit          log_wr[$];

    function automatic logic [63:0] mem_rd(input logic [63:0] a);
        if (mem.exists(a)) return mem[a];
        return {a[31:0] ^ 32'h5A5A_C3C3, ~a[31:0]};
    endfunction

    function automatic logic [63:0] gold_rd(input logic [63:0] a);
        if (gold.exists(a)) return gold[a];
        return mem_rd(a);
    endfunction

    // Memory responder: optional stall, then ready, then done one cycle after the handshake.
    int stall_left = 0;
    int stable_viol = 0;
    bit accepted = 0, stalling = 0, cap_wr = 0;
    logic [63:0] cap_addr, cap_data, cap_mask, stall_idx;

    always @(negedge clock) begin
        if (reset) begin
            accepted = 0; stalling = 0;
            m_ready = 1'b0; m_done = 1'b0; m_rdata = '0;
        end else if (accepted) begin
            accepted = 0;
            m_ready  = 1'b0;
            m_done   = 1'b1;
            log_addr.push_back(cap_addr); log_data.push_back(cap_data);
            log_mask.push_back(cap_mask); log_wr.push_back(cap_wr);
            if (cap_wr) begin
                mem[cap_addr] = (mem_rd(cap_addr) & ~cap_mask) | (cap_data & cap_mask);
                m_rdata = '0;
            end else begin
                m_rdata = mem_rd(cap_addr);
            end
        end else begin
            m_done = 1'b0; m_rdata = '0;
            if (m_valid) begin
                if (stalling && m_index !== stall_idx) stable_viol++;
                if (stall_left > 0) begin
                    if (!stalling) begin stalling = 1; stall_idx = m_index; end
                    stall_left--;
                    m_ready = 1'b0;
                end else begin
                    m_ready = 1'b1; accepted = 1; stalling = 0;
                    cap_addr = m_index; cap_data = m_wdata; cap_mask = m_wmask;
                    cap_wr = (m_op == `TBUS_WRITE);
                end
            end else begin
                if (stalling) stable_viol++;
                stalling = 0; m_ready = 1'b0;
            end
        end
    end

    // Occupancy model for the randomized test: which tags live in each set, dirtiness, rr pointer.
    bit          mv [SETS][WAYS];
    bit          md [SETS][WAYS];
    logic [63:0] mt [SETS][WAYS];
    int          mrr [SETS];

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        gold.delete();
        stall_left = 0;
        for (int s = 0; s < SETS; s++) begin
            mrr[s] = 0;
            for (int w = 0; w < WAYS; w++) begin mv[s][w] = 0; md[s][w] = 0; mt[s][w] = '0; end
        end
    endtask

    task automatic do_req(input logic [63:0] addr, input bit store, input logic [63:0] wd,
                          input logic [63:0] wm, output logic [63:0] rd, output int lat,
                          output bit timeout);
        int n;
        timeout = 1; lat = 0; rd = '0; n = 0;
        @(negedge clock);
        while (!t_ready && n < 200) begin @(negedge clock); n++; end
        t_valid = 1'b1; t_index = addr; t_wdata = wd; t_wmask = wm;
        t_op = store ? `TBUS_WRITE : `TBUS_READ;
        @(posedge clock);
        #1 t_valid = 1'b0;
        for (int i = 1; i < 2000; i++) begin
            @(negedge clock);
            if (t_done === 1'b1) begin rd = t_rdata; lat = i; timeout = 0; break; end
        end
        if (!timeout && store) gold[addr] = (gold_rd(addr) & ~wm) | (wd & wm);
        checks++;
        if (timeout) begin
            failures++;
            $display("[TB] FAIL req_timeout addr=%h: got no done, required done within 2000 cycles", addr);
        end
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clock);
        checks += 5;
        if (t_ready !== 1'b1) begin failures++; $display("[TB] FAIL reset_ready: got %b required 1", t_ready); end
        if (t_done !== 1'b0) begin failures++; $display("[TB] FAIL reset_done: got %b required 0", t_done); end
        if (t_rdata !== 64'h0) begin failures++; $display("[TB] FAIL reset_rdata: got %h required 0", t_rdata); end
        if (f_done !== 1'b0) begin failures++; $display("[TB] FAIL reset_flush_done: got %b required 0", f_done); end
        if (m_valid !== 1'b0 || m_index !== 64'h0) begin
            failures++; $display("[TB] FAIL reset_mem_bus: got valid=%b index=%h required 0/0", m_valid, m_index);
        end
    endtask

    task automatic test_miss_then_hit();
        logic [63:0] rd; int lat, mark; bit to;
        do_reset();
        mem[64'h40] = 64'h1111; mem[64'h48] = 64'h2222;
        mark = log_addr.size();
        do_req(64'h40, 0, '0, '0, rd, lat, to);
        checks += 3;
        if (rd !== 64'h1111) begin failures++; $display("[TB] FAIL miss_data: got %h required 1111", rd); end
        if (log_addr.size() - mark != 2 || log_addr[mark] !== 64'h40 || log_addr[mark+1] !== 64'h48 ||
            log_wr[mark] || log_wr[mark+1]) begin
            failures++; $display("[TB] FAIL miss_beats: got %0d beats required 2 reads at 40,48", log_addr.size() - mark);
        end
        if (lat != 2 + 2 * LW) begin failures++; $display("[TB] FAIL miss_latency: got %0d required %0d", lat, 2 + 2 * LW); end
        mark = log_addr.size();
        do_req(64'h48, 0, '0, '0, rd, lat, to);
        checks += 3;
        if (rd !== 64'h2222) begin failures++; $display("[TB] FAIL hit_data: got %h required 2222", rd); end
        if (lat != 2) begin failures++; $display("[TB] FAIL hit_latency: got %0d required 2", lat); end
        if (log_addr.size() != mark) begin failures++; $display("[TB] FAIL hit_traffic: got %0d beats required 0", log_addr.size() - mark); end
    endtask

    task automatic test_store_merge();
        logic [63:0] rd; int lat; bit to;
        do_reset();
        mem[64'h40] = 64'h1111_2222_3333_4444;
        do_req(64'h40, 0, '0, '0, rd, lat, to);
        do_req(64'h40, 1, 64'hAAAA_BBBB_CCCC_DDDD, 64'h0000_0000_FFFF_FFFF, rd, lat, to);
        do_req(64'h40, 0, '0, '0, rd, lat, to);
        checks++;
        if (rd !== 64'h1111_2222_CCCC_DDDD) begin
            failures++; $display("[TB] FAIL store_merge: got %h required 1111_2222_cccc_dddd", rd);
        end
    endtask

    task automatic test_dirty_evict();
        logic [63:0] rd, w48; int lat, mark; bit to;
        do_reset();
        do_req(64'h40, 0, '0, '0, rd, lat, to);
        do_req(64'h40, 1, 64'hDEAD_BEEF_0000_0001, '1, rd, lat, to);
        do_req(64'h140, 0, '0, '0, rd, lat, to);
        w48 = gold_rd(64'h48);
        mark = log_addr.size();
        do_req(64'h240, 0, '0, '0, rd, lat, to);
        checks += 3;
        if (log_addr.size() - mark != 4) begin
            failures++; $display("[TB] FAIL evict_beat_count: got %0d required 4", log_addr.size() - mark);
        end else begin
            if (!(log_wr[mark] && log_wr[mark+1] && !log_wr[mark+2] && !log_wr[mark+3] &&
                  log_addr[mark] === 64'h40 && log_addr[mark+1] === 64'h48 &&
                  log_addr[mark+2] === 64'h240 && log_addr[mark+3] === 64'h248)) begin
                failures++; $display("[TB] FAIL evict_order: got %h %h %h %h required 40 48 240 248 (W W R R)",
                                     log_addr[mark], log_addr[mark+1], log_addr[mark+2], log_addr[mark+3]);
            end
            if (log_data[mark] !== 64'hDEAD_BEEF_0000_0001 || log_data[mark+1] !== w48 ||
                log_mask[mark] !== '1 || log_mask[mark+1] !== '1) begin
                failures++; $display("[TB] FAIL evict_wb_data: got %h %h required deadbeef00000001 %h",
                                     log_data[mark], log_data[mark+1], w48);
            end
        end
        do_req(64'h40, 0, '0, '0, rd, lat, to);
        checks++;
        if (rd !== 64'hDEAD_BEEF_0000_0001) begin failures++; $display("[TB] FAIL evict_reload: got %h required deadbeef00000001", rd); end
    endtask

    task automatic test_stall();
        logic [63:0] rd; int lat, mark; bit to;
        do_reset();
        stable_viol = 0;
        mark = log_addr.size();
        stall_left = 5;
        do_req(64'h80, 0, '0, '0, rd, lat, to);
        checks += 3;
        if (stable_viol != 0) begin failures++; $display("[TB] FAIL stall_stable: got %0d violations required 0", stable_viol); end
        if (log_addr.size() - mark != 2 || log_addr[mark] !== 64'h80 || log_addr[mark+1] !== 64'h88) begin
            failures++; $display("[TB] FAIL stall_beats: got %0d beats required 2 (80,88)", log_addr.size() - mark);
        end
        if (rd !== mem_rd(64'h80)) begin failures++; $display("[TB] FAIL stall_data: got %h required %h", rd, mem_rd(64'h80)); end
    endtask

    task automatic test_flush();
        logic [63:0] rd; logic [63:0] exp_a [4]; logic [63:0] exp_d [4];
        int lat, mark, pulses; bit to, bad;
        do_reset();
        do_req(64'h40, 1, 64'h0123_4567_89AB_CDEF, '1, rd, lat, to);
        do_req(64'h68, 1, 64'hFEDC_BA98_7654_3210, 64'hFFFF_0000_FFFF_0000, rd, lat, to);
        do_req(64'h50, 0, '0, '0, rd, lat, to);
        exp_a[0] = 64'h40; exp_a[1] = 64'h48; exp_a[2] = 64'h60; exp_a[3] = 64'h68;
        for (int i = 0; i < 4; i++) exp_d[i] = gold_rd(exp_a[i]);
        mark = log_addr.size();
        @(negedge clock); flush_req = 1'b1;
        @(posedge clock); #1 flush_req = 1'b0;
        pulses = 0;
        for (int i = 0; i < 200; i++) begin @(negedge clock); if (f_done === 1'b1) pulses++; end
        checks += 2;
        if (pulses != 1) begin failures++; $display("[TB] FAIL flush_pulses: got %0d required 1", pulses); end
        bad = (log_addr.size() - mark != 4);
        if (!bad) for (int i = 0; i < 4; i++)
            if (log_addr[mark+i] !== exp_a[i] || log_data[mark+i] !== exp_d[i] || !log_wr[mark+i]) bad = 1;
        if (bad) begin failures++; $display("[TB] FAIL flush_beats: got %0d beats required 4 writes 40,48,60,68", log_addr.size() - mark); end
        mark = log_addr.size();
        do_req(64'h40, 0, '0, '0, rd, lat, to);
        checks += 2;
        if (log_addr.size() - mark != 2) begin failures++; $display("[TB] FAIL flush_miss: got %0d beats required 2", log_addr.size() - mark); end
        if (rd !== 64'h0123_4567_89AB_CDEF) begin failures++; $display("[TB] FAIL flush_data: got %h required 0123456789abcdef", rd); end
    endtask

    task automatic test_reset_mid_refill();
        logic [63:0] rd; int lat, mark, dones, n; bit to;
        do_reset();
        mark = log_addr.size();
        @(negedge clock);
        t_valid = 1'b1; t_index = 64'hC0; t_op = `TBUS_READ;
        @(posedge clock); #1 t_valid = 1'b0;
        n = 0;
        while (log_addr.size() == mark && n < 100) begin @(posedge clock); #1; n++; end
        dones = 0;
        reset = 1'b1;
        @(posedge clock); #1;
        checks++;
        if (m_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_mid_valid: got %b required 0", m_valid); end
        @(posedge clock); #1 reset = 1'b0;
        for (int i = 0; i < 20; i++) begin @(negedge clock); if (t_done === 1'b1) dones++; end
        checks++;
        if (dones != 0) begin failures++; $display("[TB] FAIL reset_mid_done: got %0d pulses required 0", dones); end
        mark = log_addr.size();
        do_req(64'hC0, 0, '0, '0, rd, lat, to);
        checks += 2;
        if (log_addr.size() - mark != 2) begin failures++; $display("[TB] FAIL reset_mid_remiss: got %0d beats required 2", log_addr.size() - mark); end
        if (rd !== mem_rd(64'hC0)) begin failures++; $display("[TB] FAIL reset_mid_data: got %h required %h", rd, mem_rd(64'hC0)); end
    endtask

    task automatic test_random();
        logic [63:0] addr, tg, wd, wm, rd, exp_rd;
        logic [63:0] ea[$], ed[$];
        bit ew[$];
        int s, v, hw, lat, mark; bit store, hit, to, bad;
        do_reset();
        for (int n = 0; n < 160; n++) begin
            tg = 64'h40000 + 64'($urandom_range(0, 4));
            s  = $urandom_range(0, SETS - 1);
            addr = (tg << 6) | (64'(s) << 4) | (64'($urandom_range(0, LW - 1)) << 3);
            store = $urandom_range(0, 1);
            wd = {$urandom, $urandom};
            case ($urandom_range(0, 2))
                0: wm = '1;
                1: wm = {$urandom, $urandom};
                default: wm = 64'h0000_FFFF_0000_FFFF;
            endcase
            hit = 0; hw = 0;
            for (int w = 0; w < WAYS; w++) if (mv[s][w] && mt[s][w] == tg) begin hit = 1; hw = w; end
            ea.delete(); ed.delete(); ew.delete();
            v = -1;
            if (!hit) begin
                for (int w = WAYS - 1; w >= 0; w--) if (!mv[s][w]) v = w;
                if (v < 0) begin v = mrr[s]; mrr[s] = (mrr[s] + 1) % WAYS; end
                if (mv[s][v] && md[s][v])
                    for (int k = 0; k < LW; k++) begin
                        ea.push_back((mt[s][v] << 6) | (64'(s) << 4) | (64'(k) << 3));
                        ed.push_back(gold_rd(ea[$])); ew.push_back(1);
                    end
                for (int k = 0; k < LW; k++) begin
                    ea.push_back((tg << 6) | (64'(s) << 4) | (64'(k) << 3));
                    ed.push_back('0); ew.push_back(0);
                end
            end
            exp_rd = gold_rd(addr);
            mark = log_addr.size();
            stall_left = $urandom_range(0, 2);
            do_req(addr, store, wd, wm, rd, lat, to);
            bad = (log_addr.size() - mark != ea.size());
            if (!bad) for (int i = 0; i < ea.size(); i++)
                if (log_addr[mark+i] !== ea[i] || log_wr[mark+i] != ew[i] ||
                    (ew[i] && (log_data[mark+i] !== ed[i] || log_mask[mark+i] !== '1))) bad = 1;
            checks++;
            if (bad) begin
                failures++; $display("[TB] FAIL rand_traffic #%0d addr=%h: got %0d beats required %0d", n, addr, log_addr.size() - mark, ea.size());
            end
            if (!store) begin
                checks++;
                if (rd !== exp_rd) begin failures++; $display("[TB] FAIL rand_load #%0d addr=%h: got %h required %h", n, addr, rd, exp_rd); end
            end
            if (hit) begin
                checks++;
                if (lat != 2) begin failures++; $display("[TB] FAIL rand_hit_latency #%0d: got %0d required 2", n, lat); end
                if (store) md[s][hw] = 1;
            end else begin
                mv[s][v] = 1; mt[s][v] = tg; md[s][v] = store;
            end
        end
    endtask

    initial begin
        test_reset();
        test_miss_then_hit();
        test_store_merge();
        test_dirty_evict();
        test_stall();
        test_flush();
        test_reset_mid_refill();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got no completion, required finish within 50000 cycles");
        $fatal(1, "[TB] watchdog expired");
    end
endmodule
